logic_unit_seq: RTL and testbench
=================================

# logic_unit_seq

Sequencer and two-requester arbiter for the team's 32-bit bitwise logic datapath. The datapath is built from 4-bit gate slices. The block accepts one operation at a time from either of two requesters, using round-robin arbitration. It then runs the 32-bit operation through a single 4-bit logic slice, one nibble per cycle, over 8 cycles. It returns the registered result through a valid/ready response port, tagged with the requester ID.

## Interface
- No parameters; widths are fixed: data 32 bits, slice 4 bits, 8 slices.
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester i presents an operation
- req0_ready / req1_ready  out  1  request accepted on an edge where valid & ready are both 1
- req0_op / req1_op  in  3  opcode: 000 NOT a, 001 AND, 010 OR, 011 XOR, 100 XNOR, 101 NAND, 110/111 illegal
- req0_a, req0_b / req1_a, req1_b  in  32  operands (b ignored for NOT)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  result word
- rsp_id  out  1  requester that issued the operation (0/1)
- rsp_zero  out  1  rsp_data == 0
- rsp_err  out  1  opcode was illegal
- busy  out  1  state != IDLE
- done_cnt0 / done_cnt1  out  16  completed-response count per requester; wraps 0xFFFF -> 0

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: exactly one of the two ready signals may be high.
  - Round-robin pointer ptr (reset 0). req_ptr_ready = 1. The other requester's ready = 1 only if req_ptr_valid = 0.
  - On accept: latch op, a and b into a_q, b_q, op_q. Set id_q = the accepted requester, ptr <= ~id, slice counter cnt <= 0, result register res <= 0. Go to EXEC.
- EXEC: each edge computes res[4*cnt+3:4*cnt] = f(op_q, a_q nibble, b_q nibble) and increments cnt.
  - Illegal op writes nibble 0000.
  - On the edge where cnt = 7, go to DONE.
  - Both ready signals are 0 in EXEC and DONE.
- DONE: rsp_valid = 1. rsp_data = res, rsp_id = id_q, rsp_err = op_q illegal, rsp_zero = (res == 0).
  - Outputs are held stable while rsp_ready = 0.
  - On an edge with rsp_ready = 1: increment done_cnt[id_q], go to IDLE.
  - The next request can be accepted on the following edge; there is no accept in the same cycle as the response.
- Uniform latency: illegal ops also take the full 8 EXEC cycles.
- Simultaneous valid from both requesters: the requester selected by ptr wins, and the loser's request stays pending (the requester must hold valid). Consecutive contention therefore alternates 0, 1, 0, 1.
- Operand changes on req_* after accept have no effect.
- Reset (any state, including mid-EXEC or DONE) aborts the operation with no response emitted.
  - Reset values: state IDLE, ptr 0, cnt 0, res 0, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, busy 0, done_cnt0 = done_cnt1 = 0, both ready signals 0 during the reset cycle.

## Timing
- Accept on edge E0, processing nibbles 0..7 on edges E1..E8. rsp_valid rises after E8, i.e. 8 cycles after the accept edge.
- busy is high from after E0 until after the response handshake edge.
- Minimum issue interval: 10 cycles (accept, 8 EXEC edges, response edge; IDLE is re-entered, then next accept).
- ready signals are combinational from state, ptr and valid. All rsp_* outputs and the counters are registered.

## Test plan
- Reset, then req0 AND with a=0xF0F0F0F0, b=0xFF00FF00, rsp_ready=1 -> rsp_valid exactly 8 cycles after accept; rsp_data=0xF000F000, rsp_id=0, rsp_zero=0, rsp_err=0; done_cnt0=1.
- req1 XOR with a=0x12345678, b=0xFFFFFFFF -> 0xEDCBA987, id 1. Then NOT with a=0 -> 0xFFFFFFFF. XNOR with a=b=0xA5A5A5A5 -> 0xFFFFFFFF. NAND with a=b=0xFFFFFFFF -> 0x00000000, zero=1.
- Both requesters valid continuously from reset, each issuing 3 ops -> grants ordered 0,1,0,1,0,1. No ready is asserted while busy. done_cnt0 = done_cnt1 = 3.
- Illegal op 111 with any operands -> after 8 cycles rsp_data=0, rsp_err=1, rsp_zero=1.
- Hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable and both ready signals stay 0. Raise rsp_ready -> one handshake, then IDLE; change operands after accept and confirm the result is unaffected.
- Assert reset at EXEC cnt=4 -> next cycle all outputs at reset values, no rsp_valid pulse, counters 0. Also force done_cnt0 to wrap after 65536 ops (or preload in sim) -> 0xFFFF -> 0.

Source files
------------

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: two-requester round-robin front end for the 32-bit bitwise
// logic datapath, evaluated one nibble per cycle through a single 4-bit slice.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b     request ports N = 0, 1 (valid/ready handshake)
//   rsp_valid/ready             response handshake
//   rsp_data/id/zero/err        registered result, requester tag, flags
//   busy                        operation in flight (EXEC or DONE)
//   done_cnt0/1                 completed responses per requester (wrapping)
module logic_unit_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] done_cnt0,
    output logic [15:0] done_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_ptr;
    logic        r_id;
    logic        r_err;
    logic        r_zero;
    logic        r_valid;
    logic [2:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_res;
    logic [15:0] r_done0;
    logic [15:0] r_done1;

    logic        w_acc0;
    logic        w_acc1;
    logic        w_acc;
    logic        w_acc_id;
    logic [2:0]  w_op_sel;
    logic [31:0] w_a_sel;
    logic [31:0] w_b_sel;
    logic [3:0]  w_a_nib;
    logic [3:0]  w_b_nib;
    logic [3:0]  w_nib;
    logic [31:0] w_res_nxt;
    logic        w_last;
    logic        w_hs;

    // The pointer-selected requester always sees ready; the other one only
    // when the favoured requester is not asking, so a loser keeps pending.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (r_state == IDLE && !reset) begin
            if (!r_ptr) begin
                req0_ready = 1'b1;
                req1_ready = !req0_valid;
            end else begin
                req1_ready = 1'b1;
                req0_ready = !req1_valid;
            end
        end
    end

    assign w_acc0   = req0_valid & req0_ready;
    assign w_acc1   = req1_valid & req1_ready;
    assign w_acc    = w_acc0 | w_acc1;
    assign w_acc_id = w_acc1;

    assign w_op_sel = w_acc_id ? req1_op : req0_op;
    assign w_a_sel  = w_acc_id ? req1_a  : req0_a;
    assign w_b_sel  = w_acc_id ? req1_b  : req0_b;

    assign w_a_nib  = r_a[{r_cnt, 2'b00} +: 4];
    assign w_b_nib  = r_b[{r_cnt, 2'b00} +: 4];

    // Single 4-bit gate slice; illegal opcodes yield a zero nibble.
    always_comb begin
        w_nib = 4'b0000;
        case (r_op)
            3'b000:  w_nib = ~w_a_nib;
            3'b001:  w_nib = w_a_nib & w_b_nib;
            3'b010:  w_nib = w_a_nib | w_b_nib;
            3'b011:  w_nib = w_a_nib ^ w_b_nib;
            3'b100:  w_nib = ~(w_a_nib ^ w_b_nib);
            3'b101:  w_nib = ~(w_a_nib & w_b_nib);
            default: w_nib = 4'b0000;
        endcase
    end

    always_comb begin
        w_res_nxt = r_res;
        w_res_nxt[{r_cnt, 2'b00} +: 4] = w_nib;
    end

    assign w_last = (r_state == EXEC) && (r_cnt == 3'd7);
    assign w_hs   = (r_state == DONE) && rsp_ready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_acc) w_state_nxt = EXEC;
            EXEC:    if (r_cnt == 3'd7) w_state_nxt = DONE;
            DONE:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_err   <= 1'b0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
            r_cnt   <= 3'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_res   <= 32'd0;
            r_done0 <= 16'd0;
            r_done1 <= 16'd0;
        end else begin
            if (w_acc) begin
                r_a   <= w_a_sel;
                r_b   <= w_b_sel;
                r_op  <= w_op_sel;
                r_id  <= w_acc_id;
                r_ptr <= ~w_acc_id;
                r_err <= (w_op_sel > 3'd5);
                r_cnt <= 3'd0;
                r_res <= 32'd0;
            end
            if (r_state == EXEC) begin
                r_res <= w_res_nxt;
                r_cnt <= r_cnt + 3'd1;
            end
            // Zero flag comes from the final word so it is registered
            // alongside the last nibble.
            if (w_last) begin
                r_valid <= 1'b1;
                r_zero  <= (w_res_nxt == 32'd0);
            end
            if (w_hs) begin
                r_valid <= 1'b0;
                if (r_id) begin
                    r_done1 <= r_done1 + 16'd1;
                end else begin
                    r_done0 <= r_done0 + 16'd1;
                end
            end
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_data  = r_res;
    assign rsp_id    = r_id;
    assign rsp_zero  = r_zero;
    assign rsp_err   = r_err;
    assign busy      = (r_state != IDLE);
    assign done_cnt0 = r_done0;
    assign done_cnt1 = r_done1;

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: directed and randomized bench for logic_unit_seq with a
// transaction-level reference model of arbitration, latency and results.
module tb_logic_unit_seq;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id, rsp_zero, rsp_err, busy;
    logic [15:0] done_cnt0, done_cnt1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic_unit_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .done_cnt0  (done_cnt0),
        .done_cnt1  (done_cnt1)
    );

    // requester queues (head is presented while non-empty)
    op_t q0[$];
    op_t q1[$];
    int  dut_grants[$];

    // reference model: one transaction in flight, t = edges since accept
    bit          mb;
    int          m_t;
    bit          m_ptr;
    bit          m_id;
    logic [31:0] m_exp;
    bit          m_err;
    int          m_cnt0, m_cnt1;
    bit          m_clean;
    int          acc_edge;

    bit rand_mode = 0;
    bit rst_req = 0;
    int hold_left = 0;
    int n_pass = 0;
    int n_total = 0;

    function automatic logic [31:0] ref_f(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return ~(a ^ b);
            3'd5: return ~(a & b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.op = 3'($urandom_range(0, 7));
        o.a  = $urandom;
        case ($urandom_range(0, 3))
            0: o.b = o.a;
            1: o.b = ~o.a;
            default: o.b = $urandom;
        endcase
        return o;
    endfunction

    task automatic step();
        bit e0, e1;
        int who;
        op_t o;
        @(negedge clk);
        chk("busy", 32'(busy), 32'(mb));
        chk("rsp_valid", 32'(rsp_valid), 32'(mb && m_t == 8));
        if (mb && m_t == 8) begin
            chk("rsp_data", rsp_data, m_exp);
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
            chk("rsp_zero", 32'(rsp_zero), 32'(m_exp == 0));
        end
        if (m_clean) begin
            chk("idle_data", rsp_data, 32'd0);
            chk("idle_id", 32'(rsp_id), 32'd0);
            chk("idle_err", 32'(rsp_err), 32'd0);
        end
        chk("done_cnt0", 32'(done_cnt0), 32'(m_cnt0));
        chk("done_cnt1", 32'(done_cnt1), 32'(m_cnt1));

        if (rand_mode) begin
            if (q0.size() < 3 && $urandom_range(0, 5) == 0)
                q0.push_back(rand_op());
            if (q1.size() < 3 && $urandom_range(0, 5) == 0)
                q1.push_back(rand_op());
            reset = ($urandom_range(0, 199) == 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
        end else begin
            reset = rst_req;
            rsp_ready = (hold_left == 0);
        end
        req0_valid = (q0.size() != 0);
        if (req0_valid) {req0_op, req0_a, req0_b} = q0[0];
        else {req0_op, req0_a, req0_b} = {3'($urandom), $urandom, $urandom};
        req1_valid = (q1.size() != 0);
        if (req1_valid) {req1_op, req1_a, req1_b} = q1[0];
        else {req1_op, req1_a, req1_b} = {3'($urandom), $urandom, $urandom};
        #1;
        e0 = 0;
        e1 = 0;
        if (!reset && !mb) begin
            if (m_ptr == 0) begin
                e0 = 1;
                e1 = !req0_valid;
            end else begin
                e1 = 1;
                e0 = !req1_valid;
            end
        end
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        if (req0_valid && req0_ready) dut_grants.push_back(0);
        else if (req1_valid && req1_ready) dut_grants.push_back(1);

        // model effect of the coming edge
        if (reset) begin
            mb = 0; m_t = 0; m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0; m_clean = 1;
        end else if (!mb) begin
            who = -1;
            if (m_ptr == 0) begin
                if (req0_valid) who = 0;
                else if (req1_valid) who = 1;
            end else begin
                if (req1_valid) who = 1;
                else if (req0_valid) who = 0;
            end
            if (who >= 0) begin
                o = (who == 1) ? q1.pop_front() : q0.pop_front();
                m_exp = ref_f(o.op, o.a, o.b);
                m_err = (o.op > 3'd5);
                m_id = (who == 1);
                m_ptr = (who == 0);
                mb = 1;
                m_t = 0;
                m_clean = 0;
                acc_edge = cyc + 1;
            end
        end else if (m_t < 8) begin
            m_t++;
        end else if (rsp_ready) begin
            if (m_id) m_cnt1 = (m_cnt1 + 1) % 65536;
            else m_cnt0 = (m_cnt0 + 1) % 65536;
            mb = 0;
        end
    endtask

    task automatic run_op(input int id, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input bit exp_z,
                          input bit exp_e, input int hold);
        op_t o;
        bit seen = 0;
        bit acc = 0;
        o.op = op;
        o.a = a;
        o.b = b;
        if (id == 1) q1.push_back(o);
        else q0.push_back(o);
        hold_left = hold;
        for (int n = 0; n < 60; n++) begin
            step();
            if (mb) acc = 1;
            if (rsp_valid && !seen) begin
                seen = 1;
                chk("lit_latency", 32'(cyc - acc_edge), 32'd8);
                chk("lit_data", rsp_data, exp_d);
                chk("lit_id", 32'(rsp_id), 32'(id));
                chk("lit_zero", 32'(rsp_zero), 32'(exp_z));
                chk("lit_err", 32'(rsp_err), 32'(exp_e));
            end
            if (rsp_valid && hold_left > 0) hold_left--;
            if (acc && !mb) break;
        end
        chk("lit_resp_seen", 32'(seen), 32'd1);
        hold_left = 0;
    endtask

    initial begin
        op_t o;
        int g0;
        bit fin;
        reset = 1;
        rsp_ready = 0;
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        @(posedge clk);
        mb = 0; m_t = 0; m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0; m_clean = 1;
        acc_edge = 0;
        rst_req = 1;
        step();
        step();
        rst_req = 0;
        step();

        run_op(0, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0);
        step();
        chk("lit_cnt0_first", 32'(done_cnt0), 32'd1);
        run_op(1, 3'd3, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 0, 0, 0);
        run_op(0, 3'd0, 32'h00000000, $urandom, 32'hFFFFFFFF, 0, 0, 0);
        run_op(1, 3'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hFFFFFFFF, 0, 0, 0);
        run_op(0, 3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0);
        run_op(1, 3'd7, $urandom, $urandom, 32'h00000000, 1, 1, 0);
        run_op(0, 3'd6, $urandom, $urandom, 32'h00000000, 1, 1, 0);
        run_op(0, 3'd2, 32'h0F0F0000, 32'h00F0000F, 32'h0FFF000F, 0, 0, 5);

        // contention: both requesters valid straight out of reset
        rst_req = 1;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        step();
        rst_req = 0;
        g0 = dut_grants.size();
        fin = 0;
        for (int n = 0; n < 120; n++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && !mb) begin
                fin = 1;
                break;
            end
        end
        chk("cont_finished", 32'(fin), 32'd1);
        step();
        chk("cont_grants", 32'(dut_grants.size() - g0), 32'd6);
        if (dut_grants.size() - g0 == 6)
            for (int i = 0; i < 6; i++)
                chk("cont_order", 32'(dut_grants[g0 + i]), 32'(i % 2));
        chk("cont_cnt0", 32'(done_cnt0), 32'd3);
        chk("cont_cnt1", 32'(done_cnt1), 32'd3);

        // reset mid-EXEC
        o.op = 3'd3;
        o.a = $urandom;
        o.b = $urandom;
        q0.push_back(o);
        for (int n = 0; n < 30; n++) begin
            step();
            if (mb && m_t == 4) break;
        end
        chk("abort_reached", 32'(mb && m_t == 4), 32'd1);
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", rsp_data, 32'd0);
        chk("abort_cnt0", 32'(done_cnt0), 32'd0);
        chk("abort_cnt1", 32'(done_cnt1), 32'd0);
        for (int n = 0; n < 12; n++) step();

        rand_mode = 1;
        for (int n = 0; n < 1500; n++) step();
        rand_mode = 0;
        rst_req = 0;
        fin = 0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && !mb) begin
                fin = 1;
                break;
            end
        end
        chk("drain_finished", 32'(fin), 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
